// File: rtl/bpsk_coherent_demod.sv
// Coherent BPSK demodulator: carrier mixing, integrate-and-dump over one symbol,
// saturated soft/hard decisions, optional differential decode and windowed lock detection.
module bpsk_coherent_demod #(
    parameter int unsigned SPS      = 16,
    parameter int unsigned ACC_W    = 20,
    parameter int unsigned SHIFT    = 11,
    parameter int unsigned DIFF     = 1,
    parameter int unsigned LOCK_WIN = 64,
    parameter int unsigned LOCK_TH  = 32,
    parameter int unsigned LOCK_MIN = 56
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] din,
    input  logic [7:0] carrier,
    input  logic       sync_in,
    output logic       sym_valid,
    output logic [7:0] sym_soft,
    output logic       sym_bit,
    output logic       lock
);

    localparam int unsigned CntW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int unsigned WinW = $clog2(LOCK_WIN + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SPS - 1);
    localparam logic signed [ACC_W-1:0] SatHi = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SatLo = ACC_W'(-128);

    logic signed [15:0]      prod_q;
    logic                    prod_vld_q;
    logic [CntW-1:0]         cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    prev_raw_q;
    logic [WinW-1:0]         win_cnt_q;
    logic [WinW-1:0]         good_cnt_q;

    logic                    is_dump;
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] shifted_d;
    logic [7:0]              soft_d;
    logic                    raw_d;
    logic                    bit_d;
    logic [8:0]              mag_d;
    logic                    good_d;
    logic [WinW-1:0]         good_total_d;
    logic                    win_end_d;

    always_comb begin
        is_dump   = prod_vld_q && (cnt_q == CntLast);
        sum_d     = acc_q + {{(ACC_W-16){prod_q[15]}}, prod_q};
        shifted_d = sum_d >>> SHIFT;
        if (shifted_d > SatHi) begin
            soft_d = 8'h7f;
        end else if (shifted_d < SatLo) begin
            soft_d = 8'h80;
        end else begin
            soft_d = shifted_d[7:0];
        end
        raw_d = sum_d[ACC_W-1];
        bit_d = (DIFF != 0) ? (raw_d ^ prev_raw_q) : raw_d;
        // 9-bit magnitude so that -128 maps to 128
        mag_d        = soft_d[7] ? (9'd0 - {1'b1, soft_d}) : {1'b0, soft_d};
        good_d       = (mag_d >= 9'(LOCK_TH));
        good_total_d = good_cnt_q + WinW'(good_d);
        win_end_d    = (win_cnt_q == WinW'(LOCK_WIN - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            prev_raw_q <= 1'b0;
            win_cnt_q  <= '0;
            good_cnt_q <= '0;
            sym_valid  <= 1'b0;
            sym_soft   <= '0;
            sym_bit    <= 1'b0;
            lock       <= 1'b0;
        end else begin
            prod_q     <= $signed(din) * $signed(carrier);
            prod_vld_q <= 1'b1;
            sym_valid  <= 1'b0;
            // Resync discards the partial sum; a coincident dump still completes.
            if (sync_in && (cnt_q != CntLast)) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else if (prod_vld_q) begin
                if (is_dump) begin
                    cnt_q      <= '0;
                    acc_q      <= '0;
                    sym_valid  <= 1'b1;
                    sym_soft   <= soft_d;
                    sym_bit    <= bit_d;
                    prev_raw_q <= raw_d;
                    if (win_end_d) begin
                        lock       <= (good_total_d >= WinW'(LOCK_MIN));
                        win_cnt_q  <= '0;
                        good_cnt_q <= '0;
                    end else begin
                        win_cnt_q  <= win_cnt_q + 1'b1;
                        good_cnt_q <= good_total_d;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= sum_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_bpsk_coherent_demod.sv
// Directed bench for bpsk_coherent_demod: one raw-bit (DIFF=0) and one
// differential (DIFF=1) instance share the same stimulus.
module tb_bpsk_coherent_demod;

    logic              clk = 1'b0;
    logic              reset_n;
    logic signed [7:0] din;
    logic signed [7:0] carrier;
    logic              sync_in;
    logic              v0, b0, l0, v1, b1, l1;
    logic signed [7:0] s0, s1;
    int                errors = 0;
    int                checks = 0;

    always #5 clk = ~clk;

    bpsk_coherent_demod #(.DIFF(0)) dut_raw (
        .clk(clk), .reset_n(reset_n), .din(din), .carrier(carrier), .sync_in(sync_in),
        .sym_valid(v0), .sym_soft(s0), .sym_bit(b0), .lock(l0)
    );

    bpsk_coherent_demod #(.DIFF(1)) dut_diff (
        .clk(clk), .reset_n(reset_n), .din(din), .carrier(carrier), .sync_in(sync_in),
        .sym_valid(v1), .sym_soft(s1), .sym_bit(b1), .lock(l1)
    );

    // Returns at the negedge where reset_n is released with the given inputs applied.
    task automatic do_reset(input logic signed [7:0] d, input logic signed [7:0] c);
        @(negedge clk);
        reset_n = 1'b0;
        sync_in = 1'b0;
        din     = d;
        carrier = c;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Negedges until sym_valid is seen; -1 if the budget runs out.
    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!v0 && cycles < budget);
        if (!v0) cycles = -1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; sync_in = 1'b0; din = 8'sd50; carrier = 8'sd50;
        repeat (3) @(negedge clk);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", v0); end
        checks++; if (s0 !== 8'sd0) begin errors++; $display("FAIL reset_soft: got %0d expected 0", s0); end
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL reset_bit: got %b expected 0", b0); end
        checks++; if (l0 !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", l0); end
        checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL reset_bit_diff: got %b expected 0", b1); end
    endtask

    task automatic test_phase;
        int n;
        do_reset(8'sd100, 8'sd100);
        wait_valid(40, n);
        checks++; if (n !== 17) begin errors++; $display("FAIL phase_first_latency: got %0d expected 17", n); end
        checks++; if (s0 !== 8'sd78) begin errors++; $display("FAIL phase_soft: got %0d expected 78", s0); end
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL phase_bit: got %b expected 0", b0); end
        wait_valid(40, n);
        checks++; if (n !== 16) begin errors++; $display("FAIL phase_period: got %0d expected 16", n); end
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0 || s0 !== 8'sd78) begin
            errors++; $display("FAIL phase_hold: got valid=%b soft=%0d expected valid=0 soft=78", v0, s0);
        end
    endtask

    task automatic test_sign;
        int n;
        do_reset(-8'sd100, 8'sd100);
        wait_valid(40, n);
        checks++; if (s0 !== -8'sd79) begin errors++; $display("FAIL sign_soft: got %0d expected -79", s0); end
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL sign_raw: got %b expected 1", b0); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL sign_diff1: got %b expected 1", b1); end
        wait_valid(40, n);
        checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL sign_diff2: got %b expected 0", b1); end
    endtask

    task automatic test_saturation;
        int n;
        do_reset(-8'sd128, -8'sd128);
        wait_valid(40, n);
        checks++; if (s0 !== 8'sd127) begin errors++; $display("FAIL sat_soft: got %0d expected 127", s0); end
        checks++; if (b0 !== 1'b0) begin errors++; $display("FAIL sat_raw: got %b expected 0", b0); end
        wait_valid(40, n);
        checks++; if (s0 !== 8'sd127) begin errors++; $display("FAIL sat_soft2: got %0d expected 127", s0); end
    endtask

    task automatic test_diff;
        logic signed [7:0] pat [4] = '{8'sd100, -8'sd100, -8'sd100, 8'sd100};
        logic              exp_raw [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic              exp_dif [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int                nv = 0;
        do_reset(8'sd100, 8'sd100);
        for (int c = 1; c <= 68; c++) begin
            @(negedge clk);
            if (v1 && nv < 4) begin
                checks++;
                if (b1 !== exp_dif[nv]) begin
                    errors++; $display("FAIL diff_bit[%0d]: got %b expected %b", nv, b1, exp_dif[nv]);
                end
                checks++;
                if (b0 !== exp_raw[nv]) begin
                    errors++; $display("FAIL diff_raw[%0d]: got %b expected %b", nv, b0, exp_raw[nv]);
                end
                nv++;
            end else if (v1) begin
                nv++;
            end
            din = (c / 16 < 4) ? pat[c / 16] : 8'sd100;
        end
        checks++; if (nv !== 4) begin errors++; $display("FAIL diff_count: got %0d expected 4", nv); end
    endtask

    task automatic test_resync;
        int t [3] = '{-1, -1, -1};
        int nv = 0;
        logic signed [7:0] last_soft = 8'sd0;
        do_reset(8'sd100, 8'sd100);
        for (int c = 1; c <= 56; c++) begin
            @(negedge clk);
            if (v0) begin
                if (nv < 3) t[nv] = c;
                nv++;
                last_soft = s0;
            end
            sync_in = (c == 6) || (c == 38);
            if (c == 6) din = -8'sd50;
        end
        checks++; if (t[0] !== 23) begin errors++; $display("FAIL resync_latency: got %0d expected 23", t[0]); end
        checks++; if (t[1] !== 39) begin errors++; $display("FAIL resync_coincident: got %0d expected 39", t[1]); end
        checks++; if (t[2] !== 55) begin errors++; $display("FAIL resync_next: got %0d expected 55", t[2]); end
        checks++; if (nv !== 3) begin errors++; $display("FAIL resync_count: got %0d expected 3", nv); end
        checks++; if (last_soft !== -8'sd40) begin errors++; $display("FAIL resync_soft: got %0d expected -40", last_soft); end
    endtask

    task automatic test_lock;
        int n;
        int bad = 0;
        do_reset(8'sd100, 8'sd100);
        for (int i = 1; i <= 64; i++) begin
            wait_valid(40, n);
            if (n < 0) bad++;
            if (i < 64 && l0 !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL lock_early: got %0d bad symbols expected 0", bad); end
        checks++; if (l0 !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b expected 1", l0); end
        din = 8'sd0;
        for (int i = 65; i <= 128; i++) begin
            wait_valid(40, n);
            if (i == 127) begin
                checks++; if (l0 !== 1'b1) begin errors++; $display("FAIL lock_hold: got %b expected 1", l0); end
            end
            if (i == 128) begin
                checks++; if (l1 !== 1'b0) begin errors++; $display("FAIL lock_fall: got %b expected 0", l1); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset(-8'sd100, 8'sd100);
        wait_valid(40, n);
        wait_valid(40, n);
        repeat (5) @(negedge clk);
        checks++; if (s0 !== -8'sd79) begin errors++; $display("FAIL mid_pre_soft: got %0d expected -79", s0); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0 || s0 !== 8'sd0 || b0 !== 1'b0 || l0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b s=%0d b=%b l=%b expected all 0", v0, s0, b0, l0);
        end
        din     = 8'sd100;
        reset_n = 1'b1;
        wait_valid(40, n);
        checks++; if (n !== 17) begin errors++; $display("FAIL mid_full_len: got %0d expected 17", n); end
        checks++; if (s0 !== 8'sd78) begin errors++; $display("FAIL mid_soft: got %0d expected 78", s0); end
    endtask

    initial begin
        test_reset;
        test_phase;
        test_sign;
        test_saturation;
        test_diff;
        test_resync;
        test_lock;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
